mfcc_template_matcher: RTL
==========================

Name: mfcc_template_matcher

Overview:
- Downstream consumer of the audio-processing top's 26-coefficient MFCC output vector.
- Compares each received feature vector against NUM_WORDS stored word templates using a sequential sum of absolute differences (SAD), one coefficient per cycle.
- Reports the index and distance of the closest template.
- Templates are loaded at runtime through a simple write port. The result drives the recognition/display logic.

Parameters:
- NUM_COEF, 26, coefficients per feature vector.
- NUM_WORDS, 4, number of stored templates (≥1).
- COEF_W, 16, coefficient width, signed two's complement.
- DIST_W, 22, distance width; COEF_W+1+ceil(log2(NUM_COEF)).
- THRESHOLD, 22'd20000, maximum distance accepted as a match (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- feature_in  in  [COEF_W-1:0] x [NUM_COEF-1:0]  MFCC vector, signed
- feature_valid  in  1  feature_in valid
- feature_ready  out  1  block can accept a vector
- tmpl_we  in  1  template write strobe
- tmpl_word  in  $clog2(NUM_WORDS)  template index for the write
- tmpl_coef  in  $clog2(NUM_COEF)  coefficient index for the write
- tmpl_data  in  COEF_W  coefficient value, signed
- match_id  out  $clog2(NUM_WORDS)  best template index
- match_dist  out  DIST_W  best SAD distance, unsigned
- match_valid  out  1  one-cycle result strobe
- match_found  out  1  result accepted; qualified by match_valid

Behaviour:
- FSM states: IDLE, ACCUM, CMP, DONE.
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - feature_ready=1; match_valid=0; match_found=0; match_id=0; match_dist=0.
  - Internal accumulator, best distance and counters are cleared.
  - Template storage is NOT cleared.
  - A reset mid-operation aborts the computation with no match_valid.
- IDLE:
  - feature_ready=1.
  - When feature_valid & feature_ready at edge T, all NUM_COEF coefficients are registered.
  - Word and coefficient counters are set to 0; accumulator=0; best_dist = all ones; best_id=0.
  - Transition to ACCUM. feature_ready=0 from T+1 until the return to IDLE.
- ACCUM:
  - Each cycle: acc += |feature[c] - tmpl[w][c]|.
  - Subtraction is sign-extended to COEF_W+1 bits, so there is no overflow (e.g. 32767 - (-32768) = 65535).
  - c increments each cycle. After c=NUM_COEF-1 is accumulated, transition to CMP.
- CMP (1 cycle):
  - If acc < best_dist (strict), then best_dist=acc and best_id=w. On ties the lower index wins.
  - acc is cleared and c=0.
  - If w=NUM_WORDS-1, go to DONE; else w++ and go to ACCUM.
- DONE (1 cycle):
  - match_valid=1; match_id=best_id; match_dist=best_dist; match_found per the optional feature.
  - Next state is IDLE.
- Outputs:
  - match_id and match_dist hold their values after DONE until the next DONE or reset.
  - match_valid is high only in DONE. match_found is low whenever match_valid=0.
- Latency: acceptance at edge T; match_valid is high during cycle T+1+NUM_WORDS*(NUM_COEF+1). Default: T+109.
- Throughput: one vector per 1+NUM_WORDS*27+1 cycles. Vectors offered while busy are not accepted (ready=0) and must be held by the upstream.
- Template writes:
  - Accepted only in IDLE. tmpl_we in any other state is ignored, so templates cannot change mid-comparison.
  - A write takes effect at the edge. If a write and a vector acceptance occur in the same IDLE cycle, the write is applied and the computation uses the new value.
  - Out-of-range tmpl_word or tmpl_coef writes are ignored.
- feature_valid while rst=1 is ignored.

Optional Feature:
- Macro: MATCH_THRESHOLD_EN.
- Defined: in DONE, match_found = (best_dist <= THRESHOLD).
- Undefined: match_found = 1 in DONE. THRESHOLD is unused.

Test Plan:
- Exact match:
  - Load templates: word k coefficients all = 100*k (k=0..3). Send a vector of all 200.
  - Required: match_valid exactly at T+109, match_id=2, match_dist=0, match_found=1.
- Extreme values:
  - Template 0 all -32768, others all 0. Send all 32767.
  - Required: match_id=1 (tie among 1..3 → lowest index), match_dist=26*32767=851942, no overflow.
- Tie-break:
  - Templates 0 and 3 identical (all 50), templates 1 and 2 all 1000. Send all 50.
  - Required: match_id=0, match_dist=0.
- Threshold (MATCH_THRESHOLD_EN defined):
  - Best distance 26*800=20800 → match_found=0.
  - Best distance 26*769=19994 → match_found=1.
  - Without the macro, both cases → match_found=1.
- Busy handling:
  - Assert tmpl_we to word 0 at cycle T+10 of a computation.
  - Required: write ignored, result unchanged, and feature_ready=0 from T+1 to T+109 with feature_valid held high.
  - Second vector accepted at T+110 (first IDLE cycle).
- Reset mid-operation:
  - rst=1 at T+50.
  - Required: no match_valid, feature_ready=1 the cycle after, match_id and match_dist=0.
  - Templates are retained: next vector gives correct match_id without reloading.

Source files
------------

// File: rtl/mfcc_template_matcher_if.sv
// Bus interface for mfcc_template_matcher: feature-vector handshake,
// template write port and match result.
interface mfcc_template_matcher_if #(
    parameter int unsigned NUM_COEF  = 26,
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned DIST_W    = 22
);
    localparam int unsigned WORD_IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned COEF_IW = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;

    logic [NUM_COEF-1:0][COEF_W-1:0] feature_in;
    logic                            feature_valid;
    logic                            feature_ready;
    logic                            tmpl_we;
    logic [WORD_IW-1:0]              tmpl_word;
    logic [COEF_IW-1:0]              tmpl_coef;
    logic [COEF_W-1:0]               tmpl_data;
    logic [WORD_IW-1:0]              match_id;
    logic [DIST_W-1:0]               match_dist;
    logic                            match_valid;
    logic                            match_found;

    modport master (
        output feature_in, feature_valid, tmpl_we, tmpl_word, tmpl_coef, tmpl_data,
        input  feature_ready, match_id, match_dist, match_valid, match_found
    );

    modport slave (
        input  feature_in, feature_valid, tmpl_we, tmpl_word, tmpl_coef, tmpl_data,
        output feature_ready, match_id, match_dist, match_valid, match_found
    );
endinterface

// File: rtl/mfcc_template_matcher.sv
// Nearest-template matcher: sequential SAD of an MFCC vector against NUM_WORDS
// runtime-loaded templates. Optional macro MATCH_THRESHOLD_EN gates match_found.
module mfcc_template_matcher #(
    parameter int unsigned NUM_COEF  = 26,
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned DIST_W    = 22
`ifdef MATCH_THRESHOLD_EN
    ,
    parameter logic [DIST_W-1:0] THRESHOLD = DIST_W'(20000)
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    mfcc_template_matcher_if.slave   bus
);
    localparam int unsigned WORD_IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned COEF_IW = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
    localparam int unsigned DIFF_W  = COEF_W + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, CMP, DONE} state_t;

    state_t                    r_state;
    logic signed [COEF_W-1:0]  r_feat [NUM_COEF];
    logic signed [COEF_W-1:0]  r_tmpl [NUM_WORDS][NUM_COEF];
    logic [COEF_IW-1:0]        r_coef;
    logic [WORD_IW-1:0]        r_word;
    logic [DIST_W-1:0]         r_acc;
    logic [DIST_W-1:0]         r_best_dist;
    logic [WORD_IW-1:0]        r_best_id;
    logic                      r_ready;
    logic                      r_match_valid;
    logic                      r_match_found;
    logic [WORD_IW-1:0]        r_match_id;
    logic [DIST_W-1:0]         r_match_dist;

    logic signed [COEF_W-1:0]  w_f;
    logic signed [COEF_W-1:0]  w_t;
    logic signed [DIFF_W-1:0]  w_diff;
    logic [DIFF_W-1:0]         w_absdiff;
    logic [DIST_W-1:0]         w_best_dist;
    logic [WORD_IW-1:0]        w_best_id;
    logic                      w_found;
    logic                      w_accept;
    logic                      w_wr_ok;

    // Per-cycle absolute difference, sign-extended one bit so it cannot wrap
    always_comb begin
        w_f       = r_feat[r_coef];
        w_t       = r_tmpl[r_word][r_coef];
        w_diff    = $signed({w_f[COEF_W-1], w_f}) - $signed({w_t[COEF_W-1], w_t});
        w_absdiff = w_diff[DIFF_W-1] ? DIFF_W'(-w_diff) : DIFF_W'(w_diff);
    end

    // Running minimum; strict compare keeps the lower index on ties
    always_comb begin
        w_best_dist = r_best_dist;
        w_best_id   = r_best_id;
        if (r_acc < r_best_dist) begin
            w_best_dist = r_acc;
            w_best_id   = r_word;
        end
`ifdef MATCH_THRESHOLD_EN
        w_found = (w_best_dist <= THRESHOLD);
`else
        w_found = 1'b1;
`endif
    end

    assign w_accept = (r_state == IDLE) && r_ready && bus.feature_valid;
    assign w_wr_ok  = (r_state == IDLE) && bus.tmpl_we
                      && (32'(bus.tmpl_word) < 32'(NUM_WORDS))
                      && (32'(bus.tmpl_coef) < 32'(NUM_COEF));

    // Template and feature storage survive reset
    always_ff @(posedge clk) begin
        if (w_wr_ok)
            r_tmpl[bus.tmpl_word][bus.tmpl_coef] <= bus.tmpl_data;
        if (!rst && w_accept) begin
            for (int i = 0; i < int'(NUM_COEF); i++)
                r_feat[i] <= bus.feature_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ready       <= 1'b1;
            r_match_valid <= 1'b0;
            r_match_found <= 1'b0;
            r_match_id    <= '0;
            r_match_dist  <= '0;
            r_acc         <= '0;
            r_best_dist   <= '0;
            r_best_id     <= '0;
            r_coef        <= '0;
            r_word        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_coef      <= '0;
                        r_word      <= '0;
                        r_acc       <= '0;
                        r_best_dist <= '1;
                        r_best_id   <= '0;
                        r_ready     <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_acc <= r_acc + DIST_W'(w_absdiff);
                    if (r_coef == COEF_IW'(NUM_COEF - 1))
                        r_state <= CMP;
                    else
                        r_coef <= r_coef + COEF_IW'(1);
                end
                CMP: begin
                    r_best_dist <= w_best_dist;
                    r_best_id   <= w_best_id;
                    r_acc       <= '0;
                    r_coef      <= '0;
                    if (r_word == WORD_IW'(NUM_WORDS - 1)) begin
                        r_match_valid <= 1'b1;
                        r_match_found <= w_found;
                        r_match_id    <= w_best_id;
                        r_match_dist  <= w_best_dist;
                        r_state       <= DONE;
                    end else begin
                        r_word  <= r_word + WORD_IW'(1);
                        r_state <= ACCUM;
                    end
                end
                DONE: begin
                    r_match_valid <= 1'b0;
                    r_match_found <= 1'b0;
                    r_ready       <= 1'b1;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.feature_ready = r_ready;
    assign bus.match_valid   = r_match_valid;
    assign bus.match_found   = r_match_found;
    assign bus.match_id      = r_match_id;
    assign bus.match_dist    = r_match_dist;

endmodule
